// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Burst-limited round-robin arbiter feeding one sync FIFO write port.
//            Optional counters enabled by macro FIFO_WR_ARBITER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 36,
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ce,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] din_bus,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    output logic                          fifo_we,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic [31:0]                   words_wr,
    output logic [31:0]                   stall_cnt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] c_burst_max = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    localparam logic [IDX_W-1:0] c_last_rst  = IDX_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t             r_state,      w_state_nxt;
    logic [IDX_W-1:0]   r_owner,      w_owner_nxt;
    logic [IDX_W-1:0]   r_last_owner, w_last_owner_nxt;
    logic [CNT_W-1:0]   r_burst_cnt,  w_burst_cnt_nxt;

    logic               w_keep;
    logic [IDX_W-1:0]   w_rot_sel;
    logic [IDX_W-1:0]   w_sel;
    logic [IDX_W-1:0]   w_idx;
    logic               w_accept;
    int                 w_t;

    // Rotation search runs from the farthest candidate back to the nearest so
    // the nearest requester after last_owner is the final (winning) assignment.
    always_comb begin
        w_rot_sel = r_last_owner;
        w_idx     = '0;
        w_t       = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_t = int'(r_last_owner) + k;
            if (w_t >= NUM_REQ) begin
                w_t = w_t - NUM_REQ;
            end
            w_idx = w_t[IDX_W-1:0];
            if (req[w_idx]) begin
                w_rot_sel = w_idx;
            end
        end
    end

    assign w_keep   = (r_state == ST_BURST) && req[r_owner] && (r_burst_cnt < c_burst_max);
    assign w_sel    = w_keep ? r_owner : w_rot_sel;
    assign w_accept = rst_n && ce && !fifo_full && req[w_sel];

    always_comb begin
        gnt        = '0;
        gnt[w_sel] = w_accept;
    end

    assign fifo_we  = w_accept;
    assign fifo_din = din_bus[w_sel*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_burst_cnt_nxt  = r_burst_cnt;
        if (ce) begin
            if (w_accept) begin
                if ((r_state == ST_BURST) && (w_sel == r_owner)) begin
                    // Expired burst with nobody else waiting restarts in place.
                    w_burst_cnt_nxt = (r_burst_cnt == c_burst_max) ? c_cnt_one
                                                                   : r_burst_cnt + c_cnt_one;
                end else begin
                    w_state_nxt      = ST_BURST;
                    w_owner_nxt      = w_sel;
                    w_last_owner_nxt = w_sel;
                    w_burst_cnt_nxt  = c_cnt_one;
                end
            end else if (!fifo_full && (req == '0)) begin
                w_state_nxt     = ST_IDLE;
                w_burst_cnt_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_last_owner <= c_last_rst;
            r_burst_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_burst_cnt  <= w_burst_cnt_nxt;
        end
    end

`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [31:0] r_words_wr;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_words_wr  <= '0;
            r_stall_cnt <= '0;
        end else if (ce) begin
            if (w_accept) begin
                r_words_wr <= r_words_wr + 32'd1;
            end
            if ((|req) && fifo_full) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign words_wr  = r_words_wr;
    assign stall_cnt = r_stall_cnt;
`else
    assign words_wr  = '0;
    assign stall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Directed + randomized self-checking bench for fifo_wr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fifo_wr_arbiter;

    localparam int DW = 36;
    localparam int NR = 4;
    localparam int BL = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ce = 1'b0;
    logic             fifo_full = 1'b0;
    logic [NR-1:0]    req = '0;
    logic [NR*DW-1:0] din_bus = '0;
    logic [NR-1:0]    gnt;
    logic             fifo_we;
    logic [DW-1:0]    fifo_din;
    logic [31:0]      words_wr;
    logic [31:0]      stall_cnt;

    fifo_wr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .BURST_LEN  (BL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .req       (req),
        .din_bus   (din_bus),
        .gnt       (gnt),
        .fifo_full (fifo_full),
        .fifo_we   (fifo_we),
        .fifo_din  (fifo_din),
        .words_wr  (words_wr),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: who owns the write port, how many words it has used,
    // and where the round-robin search resumes.
    bit          m_busy  = 1'b0;
    int          m_owner = 0;
    int          m_last  = NR - 1;
    int          m_cnt   = 0;
    bit [31:0]   m_words = '0;
    bit [31:0]   m_stall = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int model_sel();
        if (m_busy && req[m_owner] && m_cnt < BL) return m_owner;
        for (int k = 1; k <= NR; k++) begin
            if (req[(m_last + k) % NR]) return (m_last + k) % NR;
        end
        return -1;
    endfunction

    function automatic bit [31:0] exp_stat(input bit [31:0] v);
`ifdef FIFO_WR_ARBITER_STATS_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_gnt", 64'(gnt), 64'd0);
            chk("rst_we", 64'(fifo_we), 64'd0);
            chk("rst_words", 64'(words_wr), 64'd0);
            chk("rst_stall", 64'(stall_cnt), 64'd0);
            m_busy = 1'b0; m_owner = 0; m_last = NR - 1; m_cnt = 0;
            m_words = '0; m_stall = '0;
        end else begin
            int s;
            bit acc;
            logic [NR-1:0] eg;
            s   = model_sel();
            acc = ce && !fifo_full && (s >= 0);
            eg  = '0;
            if (acc) eg[s] = 1'b1;
            chk("gnt", 64'(gnt), 64'(eg));
            chk("fifo_we", 64'(fifo_we), 64'(acc));
            if (acc) chk("fifo_din", 64'(fifo_din), 64'(din_bus[s*DW +: DW]));
            chk("words_wr", 64'(words_wr), 64'(exp_stat(m_words)));
            chk("stall_cnt", 64'(stall_cnt), 64'(exp_stat(m_stall)));
            if (ce) begin
                if (acc) begin
                    m_words++;
                    if (m_busy && s == m_owner) begin
                        m_cnt = (m_cnt == BL) ? 1 : m_cnt + 1;
                    end else begin
                        m_busy = 1'b1; m_owner = s; m_last = s; m_cnt = 1;
                    end
                end else if (!fifo_full && req == '0) begin
                    m_busy = 1'b0; m_cnt = 0;
                end
                if (req != '0 && fifo_full) m_stall++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check one cycle's grant against a hand-computed index (-1 = none).
    task automatic step_chk(input string name, input int idx);
        logic [NR-1:0] e;
        #1;
        e = '0;
        if (idx >= 0) e[idx] = 1'b1;
        chk(name, 64'(gnt), 64'(e));
        chk({name, "_we"}, 64'(fifo_we), 64'(idx >= 0));
        tick();
    endtask

    int seq_rr[17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};

    initial begin
        for (int w = 0; w < NR; w++) din_bus[w*DW +: DW] = DW'(64'h9_0000_0000 | 64'(w * 17 + 3));
        req = 4'hF; ce = 1'b1;
        repeat (3) tick();
        #1;
        chk("reset_gnt_lit", 64'(gnt), 64'd0);
        chk("reset_words_lit", 64'(words_wr), 64'd0);
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) step_chk("rr_all_req", seq_rr[i]);

        req = 4'b0100;
        for (int i = 0; i < 10; i++) step_chk("single_req2", 2);
        req = 4'b0000;
        step_chk("idle_after_drop", -1);
        step_chk("idle_stays", -1);

        req = 4'b0011;
        step_chk("full_pre0", 0);
        step_chk("full_pre1", 0);
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) step_chk("full_hold", -1);
        fifo_full = 1'b0;
        step_chk("full_post0", 0);
        step_chk("full_post1", 0);
        step_chk("full_switch", 1);

        req = 4'b1000; ce = 1'b0;
        for (int i = 0; i < 3; i++) step_chk("ce_off", -1);
        ce = 1'b1;
        step_chk("ce_on", 3);

        req = 4'b1001;
        step_chk("own3_keep", 3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", 64'(gnt), 64'd0);
        chk("mid_rst_words", 64'(words_wr), 64'd0);
        tick();
        rst_n = 1'b1;
        step_chk("post_rst_first", 0);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 4'b0001; fifo_full = 1'b0;
        for (int i = 0; i < 20; i++) step_chk("stats_acc", 0);
        fifo_full = 1'b1;
        for (int i = 0; i < 7; i++) step_chk("stats_stall", -1);
        #1;
`ifdef FIFO_WR_ARBITER_STATS_EN
        chk("stats_words_lit", 64'(words_wr), 64'd20);
        chk("stats_stall_lit", 64'(stall_cnt), 64'd7);
`else
        chk("stats_words_lit", 64'(words_wr), 64'd0);
        chk("stats_stall_lit", 64'(stall_cnt), 64'd0);
`endif
        tick();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) req = NR'($urandom_range(0, 15));
            fifo_full = ($urandom_range(0, 3) == 0);
            ce        = ($urandom_range(0, 9) != 0);
            rst_n     = ($urandom_range(0, 199) != 0);
            for (int w = 0; w < NR; w++) din_bus[w*DW +: DW] = DW'({$urandom(), $urandom()});
            tick();
        end
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 36, SHALL set the word width of every requester and of the FIFO write port.
REQ-002 Parameter NUM_REQ, default 4, range 2..16, SHALL set the number of requesters.
REQ-003 Parameter BURST_LEN, default 4, range 1..256, SHALL set the maximum consecutive words accepted from one requester while others wait.
REQ-004 clk  input  1  single clock; all logic SHALL be on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 ce  input  1  clock enable; low SHALL freeze all state and force gnt, fifo_we to 0.
REQ-007 req  input  NUM_REQ  per-requester word-valid; held with its data until granted.
REQ-008 din_bus  input  NUM_REQ*DATA_WIDTH  requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 gnt  output  NUM_REQ  one-hot accept strobe; gnt[i]=1 means requester i's word is written this cycle.
REQ-010 fifo_full  input  1  full flag from the downstream sync FIFO.
REQ-011 fifo_we  output  1  FIFO write enable.
REQ-012 fifo_din  output  DATA_WIDTH  FIFO write data.
REQ-013 words_wr  output  32  accepted-word count (see Configuration).
REQ-014 stall_cnt  output  32  cycles with |req=1, fifo_full=1, ce=1 (see Configuration).

Function
REQ-015 Selection, gnt, fifo_we and fifo_din SHALL be combinational from current inputs and state: zero-cycle accept latency.
REQ-016 A word SHALL be accepted only when ce=1, fifo_full=0 and req of the selected requester is 1; then gnt[sel]=1, fifo_we=1, fifo_din=din_bus word sel.
REQ-017 When no word is accepted, gnt SHALL be all-zero, fifo_we 0; fifo_din SHALL still show the selected word (don't-care for checking).
REQ-018 States: IDLE (no owner) and BURST (owner register valid); burst_cnt counts accepted words of the current owner, width clog2(BURST_LEN+1).
REQ-019 Owner retention: in BURST, if req[owner]=1 and burst_cnt<BURST_LEN, sel SHALL be owner.
REQ-020 Rotation: otherwise sel SHALL be the first requesting index searching last_owner+1, +2, ... modulo NUM_REQ, ending at last_owner itself.
REQ-021 On an accept from a new owner: state BURST, owner<=sel, last_owner<=sel, burst_cnt<=1; from the same owner: burst_cnt+1.
REQ-022 BURST->IDLE when req[owner]=0 and no other req is asserted at a cycle with ce=1; burst_cnt<=0.
REQ-023 Burst expiry (burst_cnt=BURST_LEN) with no other requester SHALL let the owner continue, burst_cnt restarting at 1; no bubble cycle.
REQ-024 fifo_full=1 SHALL hold owner, last_owner, burst_cnt and state unchanged; no grant.
REQ-025 Requester switching SHALL incur no idle cycle when the FIFO is not full.
REQ-026 Counters SHALL be 32-bit unsigned and wrap modulo 2^32.

Reset
REQ-027 rst_n=0 SHALL immediately (asynchronously) force state IDLE, burst_cnt 0, last_owner NUM_REQ-1 (so index 0 wins first), words_wr 0, stall_cnt 0; gnt and fifo_we SHALL be 0 while rst_n=0.
REQ-028 Reset asserted mid-burst SHALL discard ownership; the first post-reset grant SHALL go to the lowest requesting index.

Configuration
REQ-029 Macro FIFO_WR_ARBITER_STATS_EN defined: words_wr SHALL increment on every fifo_we=1 cycle and stall_cnt per REQ-014.
REQ-030 Macro undefined: counter logic SHALL be absent and words_wr, stall_cnt tied to 0; all other behaviour identical.

Verification
REQ-031 NUM_REQ=4, BURST_LEN=4, req=4'b1111 held, fifo_full=0 -> grants 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0 on consecutive cycles, fifo_we=1 every cycle.
REQ-032 Only req[2]=1 for 10 cycles -> gnt=4'b0100 all 10 cycles; then req[2]=0 -> IDLE next cycle, gnt=0.
REQ-033 req=4'b0011, fifo_full=1 for 5 cycles mid-burst (burst_cnt=2) -> gnt=0, state held; release -> owner continues for 2 more words, then requester 1.
REQ-034 ce=0 for 3 cycles with req=4'b1000 -> gnt=0, fifo_we=0, stall_cnt unchanged; ce=1 -> gnt=4'b1000.
REQ-035 rst_n pulsed low mid-burst of requester 3 with req=4'b1001 -> gnt=0 during reset; first grant after release to requester 0; counters 0.
REQ-036 STATS_EN defined, 20 accepts and 7 full-stall cycles -> words_wr=20, stall_cnt=7; undefined -> both 0.
